mem_access: RTL

Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM register and the MEM/WB register. It takes the load/store operation latched by EX/MEM and runs it on a request/acknowledge data bus. It formats load results as byte, halfword or word. While an access is outstanding it asserts a stall request to the pipeline controller. Non-memory instructions pass straight through with no added latency.

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/mem_lane_fmt.sv | 88 ++++++++
 rtl/mem_access.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : load/store encodings, FSM states and byte enables for mem_access
// Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam int ALUOP_W = 8;
    localparam int WORD_W  = 32;

    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam logic [3:0] SEL_NONE    = 4'b0000;
    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_BYTE0   = 4'b1000;
    localparam logic [3:0] SEL_BYTE1   = 4'b0100;
    localparam logic [3:0] SEL_BYTE2   = 4'b0010;
    localparam logic [3:0] SEL_BYTE3   = 4'b0001;

    // Big-endian: byte offset 0 lives in the most significant lane.
    function automatic logic [3:0] byte_sel(input logic [1:0] offset);
        logic [3:0] sel;
        case (offset)
            2'b00:   sel = SEL_BYTE0;
            2'b01:   sel = SEL_BYTE1;
            2'b10:   sel = SEL_BYTE2;
            default: sel = SEL_BYTE3;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// mem_lane_fmt : byte-lane select, store replication and load extension
// Revision : 1.0
// ============================================================================
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [WORD_W-1:0]  reg2_i,
    input  logic [WORD_W-1:0]  rdata_i,
    output logic               is_mem_o,
    output logic               is_load_o,
    output logic               misalign_o,
    output logic [3:0]         sel_o,
    output logic [WORD_W-1:0]  wdata_o,
    output logic [WORD_W-1:0]  load_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_half_sel;

    always_comb begin
        case (addr_lo_i)
            2'b00:   w_byte = rdata_i[31:24];
            2'b01:   w_byte = rdata_i[23:16];
            2'b10:   w_byte = rdata_i[15:8];
            default: w_byte = rdata_i[7:0];
        endcase
        w_half     = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        w_half_sel = addr_lo_i[1] ? SEL_HALF_LO : SEL_HALF_HI;
    end

    always_comb begin
        is_mem_o    = 1'b0;
        is_load_o   = 1'b0;
        misalign_o  = 1'b0;
        sel_o       = SEL_NONE;
        wdata_o     = '0;
        load_data_o = '0;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: begin
                is_mem_o    = 1'b1;
                is_load_o   = 1'b1;
                sel_o       = byte_sel(addr_lo_i);
                load_data_o = (aluop_i == EXE_LB_OP) ? {{24{w_byte[7]}}, w_byte}
                                                     : {24'd0, w_byte};
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                is_mem_o    = 1'b1;
                is_load_o   = 1'b1;
                misalign_o  = addr_lo_i[0];
                sel_o       = w_half_sel;
                load_data_o = (aluop_i == EXE_LH_OP) ? {{16{w_half[15]}}, w_half}
                                                     : {16'd0, w_half};
            end
            EXE_LW_OP: begin
                is_mem_o    = 1'b1;
                is_load_o   = 1'b1;
                misalign_o  = |addr_lo_i;
                sel_o       = SEL_WORD;
                load_data_o = rdata_i;
            end
            EXE_SB_OP: begin
                is_mem_o = 1'b1;
                sel_o    = byte_sel(addr_lo_i);
                wdata_o  = {4{reg2_i[7:0]}};
            end
            EXE_SH_OP: begin
                is_mem_o   = 1'b1;
                misalign_o = addr_lo_i[0];
                sel_o      = w_half_sel;
                wdata_o    = {2{reg2_i[15:0]}};
            end
            EXE_SW_OP: begin
                is_mem_o   = 1'b1;
                misalign_o = |addr_lo_i;
                sel_o      = SEL_WORD;
                wdata_o    = reg2_i;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// mem_access : MEM stage, runs loads/stores on a req/ack bus and stalls the pipe
// Revision : 1.0
// ============================================================================
module mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         stall,
    input  logic [ALUOP_W-1:0] mem_aluop,
    input  logic [ADDR_W-1:0]  mem_mem_addr,
    input  logic [DATA_W-1:0]  mem_reg2,
    input  logic [4:0]         mem_wd,
    input  logic               mem_wreg,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_whilo,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
    output logic [4:0]         wb_wd,
    output logic               wb_wreg,
    output logic [DATA_W-1:0]  wb_wdata,
    output logic               wb_whilo,
    output logic [DATA_W-1:0]  wb_hi,
    output logic [DATA_W-1:0]  wb_lo,
    output logic               stallreq_mem,
    output logic               misalign,
    output logic               dbus_req,
    output logic               dbus_we,
    output logic [ADDR_W-1:0]  dbus_addr,
    output logic [3:0]         dbus_sel,
    output logic [DATA_W-1:0]  dbus_wdata,
    input  logic [DATA_W-1:0]  dbus_rdata,
    input  logic               dbus_ack
);

    logic              w_is_mem;
    logic              w_is_load;
    logic              w_misalign;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_load_data;
    logic              w_aligned_op;
    logic              w_stall_unused;

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              misalign_q, misalign_d;

    mem_lane_fmt u_lane_fmt (
        .aluop_i     (mem_aluop),
        .addr_lo_i   (mem_mem_addr[1:0]),
        .reg2_i      (mem_reg2),
        .rdata_i     (dbus_rdata),
        .is_mem_o    (w_is_mem),
        .is_load_o   (w_is_load),
        .misalign_o  (w_misalign),
        .sel_o       (w_sel),
        .wdata_o     (w_wdata),
        .load_data_o (w_load_data)
    );

    assign w_aligned_op   = w_is_mem & ~w_misalign;
    assign w_stall_unused = ^{stall[5], stall[3:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= SEL_NONE;
            wdata_q    <= '0;
            result_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            result_q   <= result_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        // Pulse when the misaligned op leaves the stage, so a held op reports once.
        misalign_d = w_is_mem & w_misalign & ~stall[4];
        case (state_q)
            IDLE: begin
                if (w_aligned_op) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = ~w_is_load;
                    addr_d  = {mem_mem_addr[ADDR_W-1:2], 2'b00};
                    sel_d   = w_sel;
                    wdata_d = w_wdata;
                end
            end
            BUSY: begin
                if (dbus_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (w_is_load) begin
                        result_d = w_load_data;
                    end
                end
            end
            DONE: begin
                if (!stall[4]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_wd        = mem_wd;
        wb_wreg      = mem_wreg;
        wb_wdata     = mem_wdata;
        wb_whilo     = mem_whilo;
        wb_hi        = mem_hi;
        wb_lo        = mem_lo;
        stallreq_mem = w_aligned_op & (state_q != DONE);
        if (w_is_mem) begin
            wb_wreg = mem_wreg & w_is_load & ~w_misalign;
            if (!w_misalign) begin
                wb_wdata = result_q;
            end
        end
        if (!rst) begin
            wb_wd        = '0;
            wb_wreg      = 1'b0;
            wb_wdata     = '0;
            wb_whilo     = 1'b0;
            wb_hi        = '0;
            wb_lo        = '0;
            stallreq_mem = 1'b0;
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_sel   = sel_q;
    assign dbus_wdata = wdata_q;
    assign misalign   = misalign_q;

endmodule
`default_nettype wire
